led_round_engine: RTL and testbench



---
 rtl/led_round_engine.sv | 70 +++++++
 tb/tb_led_round_engine.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_round_engine.sv
// led_round_engine: iterative LED-64 round core (AddConstants, SubCells, ShiftRows, key add)
// wrapped around an external combinational MixColumnSerial stage.
module led_round_engine #(
   parameter int ROUNDS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [63:0] pt,
   input  logic [63:0] key,
   output logic        busy,
   output logic        done,
   output logic [63:0] ct,
   output logic [63:0] mc_b,
   input  logic [63:0] mc_c
);
   localparam int RW = $clog2(ROUNDS);
   localparam logic [RW-1:0] LAST = RW'(ROUNDS - 1);
   localparam logic [63:0] SBOX = 64'h2174_8FE3_DA09_B65C;
   typedef enum logic {IDLE, RUN} fsm_t;
   fsm_t fsm;
   logic [63:0] state, key_reg, ac, sb, next_state;
   logic [5:0] rc, rc_n;
   logic [RW-1:0] r;
   assign rc_n = {rc[4:0], ~(rc[5] ^ rc[4])};
   assign ac = state ^ {4'h4, 1'b0, rc_n[5:3], 8'h0,
                        4'h5, 1'b0, rc_n[2:0], 8'h0,
                        4'h2, 1'b0, rc_n[5:3], 8'h0,
                        4'h3, 1'b0, rc_n[2:0], 8'h0};
   for (genvar g = 0; g < 16; g++) begin : g_sbox
      assign sb[4*g +: 4] = SBOX[{ac[4*g +: 4], 2'b00} +: 4];
   end
   // row i rotates left by i nibbles
   assign mc_b = {sb[63:48], sb[43:32], sb[47:44], sb[23:16], sb[31:24], sb[3:0], sb[15:4]};
   assign next_state = mc_c ^ (&r[1:0] ? key_reg : 64'h0);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm     <= IDLE;
         state   <= '0;
         key_reg <= '0;
         rc      <= '0;
         r       <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         ct      <= '0;
      end else begin
         done <= 1'b0;
         if (fsm == IDLE) begin
            if (start) begin
               state   <= pt ^ key;
               key_reg <= key;
               rc      <= '0;
               r       <= '0;
               busy    <= 1'b1;
               fsm     <= RUN;
            end
         end else begin
            state <= next_state;
            rc    <= rc_n;
            r     <= r + 1'b1;
            if (r == LAST) begin
               ct   <= next_state;
               done <= 1'b1;
               busy <= 1'b0;
               fsm  <= IDLE;
            end
         end
      end
   end
endmodule

// File: tb/tb_led_round_engine.sv
// tb_led_round_engine: directed checks of the LED-64 round engine, with a reference
// MixColumnSerial closing the loop on mc_b -> mc_c.
module tb_led_round_engine;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic [63:0] pt = '0;
   logic [63:0] key = '0;
   logic busy, done;
   logic [63:0] ct, mc_b, mc_c;
   int n_cmp = 0;
   int n_err = 0;

   localparam logic [63:0] CT_ZERO = 64'h39C2401003A0C798;
   localparam logic [63:0] CT_NZ   = 64'hA003551E3893FC58;
   localparam logic [63:0] V_NZ    = 64'h0123456789ABCDEF;
   localparam logic [63:0] MC      = 64'h4122_8656_BEA9_22FB;

   led_round_engine #(.ROUNDS(32)) dut (
      .clk(clk), .rst(rst), .start(start), .pt(pt), .key(key),
      .busy(busy), .done(done), .ct(ct), .mc_b(mc_b), .mc_c(mc_c)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] nib(input logic [63:0] x, input int i, input int j);
      return x[60 - 16*i - 4*j +: 4];
   endfunction

   function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] p, x;
      p = '0;
      x = a;
      for (int t = 0; t < 4; t++) begin
         if (b[t]) p ^= x;
         x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
      end
      return p;
   endfunction

   function automatic logic [63:0] mcs(input logic [63:0] x);
      logic [63:0] o;
      logic [3:0] acc;
      o = '0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            acc = '0;
            for (int k = 0; k < 4; k++) acc ^= gmul(nib(MC, i, k), nib(x, k, j));
            o[60 - 16*i - 4*j +: 4] = acc;
         end
      return o;
   endfunction

   function automatic logic [3:0] present_sbox(input logic [3:0] v);
      case (v)
         4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
         4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
         4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
         4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
      endcase
   endfunction

   // reference AC + SC + SR for one round, given the round constant actually used
   function automatic logic [63:0] model_mcb(input logic [63:0] s, input logic [5:0] rcv);
      logic [63:0] o;
      logic [3:0] v;
      logic [3:0] c0 [4];
      c0 = '{4'h4, 4'h5, 4'h2, 4'h3};
      o = '0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            v = nib(s, i, j);
            if (j == 0) v ^= c0[i];
            if (j == 1) v ^= (i % 2 == 0) ? {1'b0, rcv[5:3]} : {1'b0, rcv[2:0]};
            o[60 - 16*i - 4*((j - i + 4) % 4) +: 4] = present_sbox(v);
         end
      return o;
   endfunction

   always_comb mc_c = mcs(mc_b);

   task automatic start_run(input logic [63:0] p, input logic [63:0] k);
      @(negedge clk);
      pt = p;
      key = k;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output int busy_cnt);
      cyc = 0;
      busy_cnt = 0;
      while (done !== 1'b1 && cyc < 40) begin
         if (busy === 1'b1) busy_cnt++;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset;
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({busy, done, ct} !== 66'h0) begin
         n_err++;
         $display("FAIL reset_async: busy=%b done=%b ct=%h, required all 0", busy, done, ct);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({busy, done, ct} !== 66'h0) begin
            n_err++;
            $display("FAIL reset_idle cyc %0d: busy=%b done=%b ct=%h, required all 0", i, busy, done, ct);
         end
      end
   endtask

   task automatic test_zero_vector;
      int cyc, bc;
      start_run(64'h0, 64'h0);
      wait_done(cyc, bc);
      n_cmp++;
      if (cyc !== 32) begin n_err++; $display("FAIL zero_latency: got %0d cycles, required 32", cyc); end
      n_cmp++;
      if (bc !== 32) begin n_err++; $display("FAIL zero_busy_len: got %0d, required 32", bc); end
      n_cmp++;
      if (ct !== CT_ZERO) begin n_err++; $display("FAIL zero_ct: got %h, required %h", ct, CT_ZERO); end
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy_end: got %b, required 0", busy); end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin n_err++; $display("FAIL zero_done_pulse: got %b, required 0", done); end
   endtask

   task automatic test_constants_tap;
      logic [5:0] rc_tab [8];
      logic [63:0] s, exp_b;
      int cyc, bc;
      rc_tab = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B};
      start_run(64'h0, 64'h0);
      n_cmp++;
      if (mc_b !== 64'h9CCC5CC0CC6CCB5C) begin
         n_err++;
         $display("FAIL tap_round0: got %h, required 9ccc5cc0cc6ccb5c", mc_b);
      end
      s = '0;
      for (int k = 0; k < 8; k++) begin
         exp_b = model_mcb(s, rc_tab[k]);
         n_cmp++;
         if (mc_b !== exp_b) begin
            n_err++;
            $display("FAIL tap_round%0d: got %h, required %h", k, mc_b, exp_b);
         end
         s = mcs(exp_b);
         @(negedge clk);
      end
      wait_done(cyc, bc);
      n_cmp++;
      if (ct !== CT_ZERO) begin n_err++; $display("FAIL tap_ct: got %h, required %h", ct, CT_ZERO); end
      @(negedge clk);
   endtask

   task automatic test_nonzero_vector;
      int cyc, bc;
      start_run(V_NZ, V_NZ);
      wait_done(cyc, bc);
      n_cmp++;
      if (cyc !== 32) begin n_err++; $display("FAIL nz_latency: got %0d cycles, required 32", cyc); end
      n_cmp++;
      if (ct !== CT_NZ) begin n_err++; $display("FAIL nz_ct: got %h, required %h", ct, CT_NZ); end
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         n_cmp++;
         if (ct !== CT_NZ || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL nz_hold cyc %0d: ct=%h busy=%b done=%b, required %h/0/0", i, ct, busy, done, CT_NZ);
         end
      end
   endtask

   task automatic test_ignored_start;
      int cyc, bc, dones;
      start_run(64'h0, 64'h0);
      cyc = 0;
      dones = 0;
      while (cyc < 32) begin
         if (cyc == 4) begin start = 1'b1; pt = '1; end
         if (cyc == 5) start = 1'b0;
         if (cyc == 10) key = V_NZ;
         if (cyc == 31) begin start = 1'b1; pt = V_NZ; end
         @(negedge clk);
         cyc++;
         if (done === 1'b1) dones++;
      end
      n_cmp++;
      if (dones !== 1 || done !== 1'b1) begin
         n_err++;
         $display("FAIL ign_done: got %0d pulses done=%b at cycle 32, required 1 pulse done=1", dones, done);
      end
      n_cmp++;
      if (ct !== CT_ZERO) begin n_err++; $display("FAIL ign_ct: got %h, required %h", ct, CT_ZERO); end
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL ign_busy_completion: got %b, required 0", busy); end
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL ign_restart_e33: busy got %b, required 1", busy); end
      wait_done(cyc, bc);
      n_cmp++;
      if (cyc !== 32) begin n_err++; $display("FAIL ign_second_latency: got %0d, required 32", cyc); end
      n_cmp++;
      if (ct !== CT_NZ) begin n_err++; $display("FAIL ign_second_ct: got %h, required %h", ct, CT_NZ); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run;
      int cyc, bc, dones;
      start_run(V_NZ, V_NZ);
      repeat (17) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({busy, done, ct} !== 66'h0) begin
         n_err++;
         $display("FAIL midrst_async: busy=%b done=%b ct=%h, required all 0", busy, done, ct);
      end
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) dones++;
      end
      n_cmp++;
      if (dones !== 0) begin n_err++; $display("FAIL midrst_quiet: got %0d active cycles, required 0", dones); end
      start_run(V_NZ, V_NZ);
      wait_done(cyc, bc);
      n_cmp++;
      if (cyc !== 32 || ct !== CT_NZ) begin
         n_err++;
         $display("FAIL midrst_rerun: got %0d cycles ct=%h, required 32 cycles ct=%h", cyc, ct, CT_NZ);
      end
   endtask

   initial begin
      test_reset;
      test_zero_vector;
      test_constants_tap;
      test_nonzero_vector;
      test_ignored_start;
      test_reset_mid_run;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
